// File: rtl/seq_cla_subtractor.sv
// Multi-cycle subtractor, diff = a - b - bin. One 4-bit borrow-look-ahead slice per clock, LSB first.
// Result is valid NS edges after accept and is held in DONE until out_ready; in_ready only in IDLE.
module seq_cla_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NS = WIDTH / 4;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic [WIDTH-1:0] a_r, b_r, res, res_nxt;
  logic [3:0]       g, p, c, sl;
  logic             c4, last;

  // Operands shift right each CALC edge, so the active slice always sits in bits [3:0].
  assign g = a_r[3:0] & ~b_r[3:0];
  assign p = a_r[3:0] ^ ~b_r[3:0];

  assign c[0] = ~brw;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sl   = p ^ c;
  assign last = (cnt == CW'(NS - 1));

  generate
    if (WIDTH > 4) begin : g_wide
      assign res_nxt = {sl, res[WIDTH-1:4]};
    end else begin : g_narrow
      assign res_nxt = sl;
    end
  endgenerate

  assign in_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      brw       <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      res       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            brw <= bin;
            cnt <= '0;
          end
        end
        CALC: begin
          a_r <= a_r >> 4;
          b_r <= b_r >> 4;
          brw <= ~c4;
          res <= res_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            // On the last slice a_r[3]/b_r[3] are the original operand sign bits.
            diff      <= res_nxt;
            bout      <= ~c4;
            ovf       <= (a_r[3] ^ b_r[3]) & (sl[3] ^ a_r[3]);
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// Directed bench for seq_cla_subtractor (WIDTH=16): vector table plus hand sequences for
// backpressure, back-to-back accept and asynchronous reset mid-operation.
module tb_seq_cla_subtractor;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  seq_cla_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called just after a negedge with the DUT idle.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                       input logic [W-1:0] ed, input logic eb, input logic eo, input bit consume);
    int n;
    in_valid = 1'b1; a = ta; b = tb_v; bin = tbin;
    chk("in_ready_idle", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    chk("in_ready_calc", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("latency", n, 4);
    chk("diff", diff, ed);
    chk("bout", bout, eb);
    chk("ovf", ovf, eo);
    if (consume) begin
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("consume_out_valid", out_valid, 0);
      chk("consume_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
    vecs[1] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
    vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'h0FFF, 16'h0FFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[7] = '{16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[8] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1};
    vecs[9] = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].ovf, 1'b1);

    // Backpressure in DONE with input noise
    do_op(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'b1;
      cyc();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_diff", diff, 16'h1200);
      chk("bp_bout", bout, 0);
      chk("bp_in_ready", in_ready, 0);
    end

    // Consume with in_valid held high: accepted on the first IDLE edge
    in_valid = 1'b1; a = 16'h0010; b = 16'h0001; bin = 1'b0; out_ready = 1'b1;
    cyc();
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_diff_held", diff, 16'h1200);
    cyc();
    in_valid = 1'b0;
    chk("b2b_in_ready", in_ready, 0);
    repeat (3) cyc();
    chk("calc_ignores_out_ready", out_valid, 0);
    chk("calc_diff_held", diff, 16'h1200);
    cyc();
    chk("b2b_out_valid", out_valid, 1);
    chk("b2b_diff", diff, 16'h000F);
    cyc();
    out_ready = 1'b0;
    chk("b2b_consumed", out_valid, 0);

    // Reset after two CALC edges
    in_valid = 1'b1; a = 16'h0000; b = 16'h0001; bin = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rcalc_out_valid", out_valid, 0);
    chk("rcalc_diff", diff, 0);
    chk("rcalc_bout", bout, 0);
    chk("rcalc_ovf", ovf, 0);
    chk("rcalc_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);

    // Reset while holding a result in DONE
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rdone_out_valid", out_valid, 0);
    chk("rdone_diff", diff, 0);
    chk("rdone_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0FFF, 16'h0FFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
